// File: rtl/rom_bus_arbiter.sv
// Shares one SRAM port between SNES cycles (priority) and one-deep queued MCU requests.
// Latency: request strobe to data/done pulse is 1+ACC_CYCLES clocks on an idle bus; MCU waits behind SNES via mcu_rq_rdy.
module rom_bus_arbiter #(
   parameter int ACC_CYCLES = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        snes_rd_start,
   input  logic        snes_wr_start,
   input  logic [23:0] snes_addr,
   input  logic        snes_hit,
   input  logic        snes_writable,
   input  logic [7:0]  snes_wrdata,
   output logic [7:0]  snes_rddata,
   output logic        snes_rd_valid,
   input  logic        mcu_rrq,
   input  logic        mcu_wrq,
   input  logic [23:0] mcu_addr,
   input  logic [7:0]  mcu_wrdata,
   output logic [7:0]  mcu_rddata,
   output logic        mcu_rq_rdy,
   output logic        mcu_done,
   output logic [23:0] sram_addr,
   output logic [7:0]  sram_dout,
   input  logic [7:0]  sram_din,
   output logic        sram_oe_data,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n
);

   typedef enum logic [2:0] {IDLE, SRD, SWR, MRD, MWR, REC} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        spend, s_wr;
   logic [23:0] s_addr;
   logic [7:0]  s_data;
   logic        mpend, m_wr;
   logic [23:0] m_addr;
   logic [7:0]  m_data;

   logic s_cap_wr, s_cap, m_cap;

   always_comb begin
      s_cap_wr = snes_wr_start && snes_writable;
      s_cap    = snes_hit && (snes_rd_start || s_cap_wr);
      m_cap    = (mcu_rrq || mcu_wrq) && mcu_rq_rdy;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state         <= IDLE;
         cnt           <= 4'd0;
         spend         <= 1'b0;
         s_wr          <= 1'b0;
         s_addr        <= 24'd0;
         s_data        <= 8'd0;
         mpend         <= 1'b0;
         m_wr          <= 1'b0;
         m_addr        <= 24'd0;
         m_data        <= 8'd0;
         snes_rddata   <= 8'd0;
         snes_rd_valid <= 1'b0;
         mcu_rddata    <= 8'd0;
         mcu_rq_rdy    <= 1'b1;
         mcu_done      <= 1'b0;
         sram_addr     <= 24'd0;
         sram_dout     <= 8'd0;
         sram_oe_data  <= 1'b0;
         sram_ce_n     <= 1'b1;
         sram_oe_n     <= 1'b1;
         sram_we_n     <= 1'b1;
      end else begin
         snes_rd_valid <= 1'b0;
         mcu_done      <= 1'b0;
         case (state)
            // REC arbitrates like IDLE so its single dead clock is the only gap between accesses
            IDLE, REC: begin
               if (spend) begin
                  state        <= s_wr ? SWR : SRD;
                  spend        <= 1'b0;
                  sram_addr    <= s_addr;
                  if (s_wr) sram_dout <= s_data;
                  sram_ce_n    <= 1'b0;
                  sram_oe_n    <= s_wr;
                  sram_we_n    <= !s_wr;
                  sram_oe_data <= s_wr;
                  cnt          <= 4'(ACC_CYCLES - 1);
               end else if (mpend) begin
                  state        <= m_wr ? MWR : MRD;
                  mpend        <= 1'b0;
                  sram_addr    <= m_addr;
                  if (m_wr) sram_dout <= m_data;
                  sram_ce_n    <= 1'b0;
                  sram_oe_n    <= m_wr;
                  sram_we_n    <= !m_wr;
                  sram_oe_data <= m_wr;
                  cnt          <= 4'(ACC_CYCLES - 1);
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               if (cnt == 4'd0) begin
                  state        <= REC;
                  sram_ce_n    <= 1'b1;
                  sram_oe_n    <= 1'b1;
                  sram_we_n    <= 1'b1;
                  sram_oe_data <= 1'b0;
                  if (state == SRD) begin
                     snes_rddata   <= sram_din;
                     snes_rd_valid <= 1'b1;
                  end
                  if (state == MRD) mcu_rddata <= sram_din;
                  if (state == MRD || state == MWR) mcu_done <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
         endcase

         // Captures come last so a strobe on a launch edge refills the slot just emptied
         if (s_cap) begin
            spend  <= 1'b1;
            s_wr   <= s_cap_wr;
            s_addr <= snes_addr;
            s_data <= snes_wrdata;
         end
         if (m_cap) begin
            mpend      <= 1'b1;
            m_wr       <= mcu_wrq;
            m_addr     <= mcu_addr;
            m_data     <= mcu_wrdata;
            mcu_rq_rdy <= 1'b0;
         end else if (mcu_done) begin
            mcu_rq_rdy <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Bench for rom_bus_arbiter: directed scenarios then random traffic, checked every clock against an access-schedule model.
module tb_rom_bus_arbiter;
   localparam int ACC = 4;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        snes_rd_start, snes_wr_start, snes_hit, snes_writable;
   logic [23:0] snes_addr;
   logic [7:0]  snes_wrdata;
   logic [7:0]  snes_rddata;
   logic        snes_rd_valid;
   logic        mcu_rrq, mcu_wrq;
   logic [23:0] mcu_addr;
   logic [7:0]  mcu_wrdata;
   logic [7:0]  mcu_rddata;
   logic        mcu_rq_rdy, mcu_done;
   logic [23:0] sram_addr;
   logic [7:0]  sram_dout, sram_din;
   logic        sram_oe_data, sram_ce_n, sram_oe_n, sram_we_n;

   rom_bus_arbiter #(.ACC_CYCLES(ACC)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .snes_rd_start(snes_rd_start), .snes_wr_start(snes_wr_start),
      .snes_addr(snes_addr), .snes_hit(snes_hit), .snes_writable(snes_writable),
      .snes_wrdata(snes_wrdata), .snes_rddata(snes_rddata), .snes_rd_valid(snes_rd_valid),
      .mcu_rrq(mcu_rrq), .mcu_wrq(mcu_wrq), .mcu_addr(mcu_addr), .mcu_wrdata(mcu_wrdata),
      .mcu_rddata(mcu_rddata), .mcu_rq_rdy(mcu_rq_rdy), .mcu_done(mcu_done),
      .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
      .sram_oe_data(sram_oe_data), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Reference model: a pending-request list per master and one scheduled access
   // (start edge, kind); bus outputs follow from where the current edge falls in that schedule.
   int          k = 0;
   bit          act = 0, a_wr = 0, a_snes = 0;
   int          s_edge = 0, free_at = 0, done_edge = -10;
   bit          sp_v = 0, sp_wr = 0, mp_v = 0, mp_wr = 0, m_rdy = 1;
   logic [23:0] sp_a = 0, mp_a = 0, e_addr = 0;
   logic [7:0]  sp_d = 0, mp_d = 0, e_dout = 0, e_srd = 0, e_mrd = 0;
   bit          e_valid = 0, e_done = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, k);
      end
   endtask

   task automatic model_step();
      k++;
      if (!RST_N) begin
         act = 0; free_at = 0; done_edge = -10;
         sp_v = 0; mp_v = 0; m_rdy = 1;
         e_addr = 0; e_dout = 0; e_srd = 0; e_mrd = 0; e_valid = 0; e_done = 0;
      end else begin
         e_valid = 0;
         e_done  = 0;
         if (act && k == s_edge + ACC) begin
            act = 0;
            free_at = k + 1;
            if (!a_wr && a_snes) begin e_srd = sram_din; e_valid = 1; end
            if (!a_wr && !a_snes) e_mrd = sram_din;
            if (!a_snes) begin e_done = 1; done_edge = k; end
         end
         if (!act && k >= free_at && (sp_v || mp_v)) begin
            act = 1; s_edge = k; a_snes = sp_v;
            a_wr   = sp_v ? sp_wr : mp_wr;
            e_addr = sp_v ? sp_a : mp_a;
            if (a_wr) e_dout = sp_v ? sp_d : mp_d;
            if (sp_v) sp_v = 0; else mp_v = 0;
         end
         if (snes_hit && ((snes_wr_start && snes_writable) || snes_rd_start)) begin
            sp_v = 1; sp_wr = snes_wr_start && snes_writable;
            sp_a = snes_addr; sp_d = snes_wrdata;
         end
         if ((mcu_rrq || mcu_wrq) && m_rdy) begin
            mp_v = 1; mp_wr = mcu_wrq; mp_a = mcu_addr; mp_d = mcu_wrdata; m_rdy = 0;
         end else if (k == done_edge + 1) begin
            m_rdy = 1;
         end
      end
   endtask

   task automatic compare();
      chk("ce_n",      32'(sram_ce_n),     32'(!act));
      chk("oe_n",      32'(sram_oe_n),     32'(!(act && !a_wr)));
      chk("we_n",      32'(sram_we_n),     32'(!(act && a_wr)));
      chk("oe_data",   32'(sram_oe_data),  32'(act && a_wr));
      chk("sram_addr", 32'(sram_addr),     32'(e_addr));
      chk("sram_dout", 32'(sram_dout),     32'(e_dout));
      chk("snes_rd",   32'(snes_rddata),   32'(e_srd));
      chk("rd_valid",  32'(snes_rd_valid), 32'(e_valid));
      chk("mcu_rd",    32'(mcu_rddata),    32'(e_mrd));
      chk("mcu_done",  32'(mcu_done),      32'(e_done));
      chk("rq_rdy",    32'(mcu_rq_rdy),    32'(m_rdy));
   endtask

   task automatic step();
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      compare();
   endtask

   task automatic clr();
      snes_rd_start = 0; snes_wr_start = 0; mcu_rrq = 0; mcu_wrq = 0;
   endtask

   initial begin
      int n;
      int first;
      clr();
      snes_hit = 0; snes_writable = 0; snes_addr = 0; snes_wrdata = 0;
      mcu_addr = 0; mcu_wrdata = 0; sram_din = 0;
      RST_N = 0;
      repeat (3) step();
      RST_N = 1;
      step();
      chk("reset_ce_n", 32'(sram_ce_n), 32'd1);
      chk("reset_rdy",  32'(mcu_rq_rdy), 32'd1);

      // SNES read on an idle bus
      sram_din = 8'hA5; snes_addr = 24'h123456; snes_hit = 1; snes_rd_start = 1;
      step(); clr();
      for (int i = 1; i <= ACC; i++) begin
         step();
         chk("srd_addr", 32'(sram_addr), 32'h123456);
         chk("srd_oe_n", 32'(sram_oe_n), 32'd0);
      end
      step();
      chk("srd_valid", 32'(snes_rd_valid), 32'd1);
      chk("srd_data",  32'(snes_rddata), 32'hA5);
      repeat (3) step();

      // SNES write to a non-writable region is dropped
      snes_wr_start = 1; snes_writable = 0; snes_wrdata = 8'h3C;
      step(); clr();
      for (int i = 0; i < 6; i++) begin
         step();
         chk("nowr_ce_n", 32'(sram_ce_n), 32'd1);
      end
      snes_wr_start = 1; snes_writable = 1;
      step(); clr();
      for (int i = 1; i <= ACC; i++) begin
         step();
         chk("swr_we_n", 32'(sram_we_n), 32'd0);
         chk("swr_dout", 32'(sram_dout), 32'h3C);
         chk("swr_oed",  32'(sram_oe_data), 32'd1);
      end
      repeat (3) step();

      // Simultaneous SNES and MCU reads
      snes_addr = 24'h400000; snes_rd_start = 1; mcu_addr = 24'h000010; mcu_rrq = 1;
      step(); clr();
      for (int i = 1; i <= ACC; i++) begin
         step();
         chk("sim_snes_addr", 32'(sram_addr), 32'h400000);
      end
      step();
      chk("sim_rec_ce_n", 32'(sram_ce_n), 32'd1);
      step();
      chk("sim_mcu_addr", 32'(sram_addr), 32'h000010);
      repeat (3) step();
      step();
      chk("sim_done", 32'(mcu_done), 32'd1);
      step();
      chk("sim_rdy", 32'(mcu_rq_rdy), 32'd1);
      repeat (2) step();

      // SNES strobe one clock into an MCU write
      mcu_addr = 24'h00ABCD; mcu_wrdata = 8'h77; mcu_wrq = 1;
      step(); clr();
      step();
      snes_addr = 24'h222222; snes_rd_start = 1;
      step(); clr();
      first = -1;
      for (int e = 3; e <= 12; e++) begin
         step();
         if (first < 0 && !sram_ce_n && sram_addr == 24'h222222) first = e;
      end
      chk("snes_wait_ok", 32'((first > 2) && (first - 2 <= ACC + 1)), 32'd1);

      // MCU strobe while busy is ignored
      sram_din = 8'h5A; mcu_addr = 24'h000100; mcu_rrq = 1;
      step(); clr();
      step();
      mcu_addr = 24'h000200; mcu_wrdata = 8'hEE; mcu_wrq = 1;
      step(); clr();
      n = 0;
      repeat (12) begin
         step();
         if (mcu_done) n++;
      end
      chk("one_done", 32'(n), 32'd1);
      chk("ign_rd",   32'(mcu_rddata), 32'h5A);

      // Reset in the middle of an MCU write
      mcu_addr = 24'h000300; mcu_wrdata = 8'h11; mcu_wrq = 1;
      step(); clr();
      repeat (2) step();
      RST_N = 0;
      step();
      RST_N = 1;
      chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_oed",  32'(sram_oe_data), 32'd0);
      chk("rst_rdy",  32'(mcu_rq_rdy), 32'd1);
      repeat (2) step();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         sram_din      = 8'($urandom);
         snes_rd_start = ($urandom_range(0, 9) == 0);
         snes_wr_start = ($urandom_range(0, 11) == 0);
         snes_hit      = ($urandom_range(0, 3) != 0);
         snes_writable = ($urandom_range(0, 1) == 1);
         snes_addr     = 24'($urandom);
         snes_wrdata   = 8'($urandom);
         mcu_rrq       = ($urandom_range(0, 5) == 0);
         mcu_wrq       = ($urandom_range(0, 5) == 0);
         mcu_addr      = 24'($urandom);
         mcu_wrdata    = 8'($urandom);
         RST_N         = ($urandom_range(0, 299) != 0);
         step();
      end
      clr();
      RST_N = 1;
      repeat (8) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rom_bus_arbiter.md
# rom_bus_arbiter

Sequences and shares the single external ROM/SRAM port (SRAM0) between SNES bus cycles and MCU memory requests. Sits between the address decoder (which supplies the translated SNES address and hit/writable qualifiers) and the SRAM pins. SNES cycles have strict priority; MCU requests are queued one-deep and serviced in idle gaps. Every access is a fixed-length SRAM cycle followed by a one-clock recovery.

## Interface
- `ACC_CYCLES`, 4: clocks per SRAM access with CE/OE or CE/WE asserted (legal range 2..15).
- `CLK` in 1: system clock.
- `RST_N` in 1: synchronous, active-low reset.
- `snes_rd_start` in 1: one-clock strobe; an SNES read cycle has begun (synchronised upstream).
- `snes_wr_start` in 1: one-clock strobe; an SNES write data is valid.
- `snes_addr` in 24: translated SNES address from the decoder.
- `snes_hit` in 1: decoder ROM_HIT; strobes are ignored when low.
- `snes_writable` in 1: decoder IS_WRITABLE; SNES writes are ignored when low.
- `snes_wrdata` in 8: SNES write data, sampled on `snes_wr_start`.
- `snes_rddata` out 8: last SNES read data.
- `snes_rd_valid` out 1: one-clock pulse when `snes_rddata` updates.
- `mcu_rrq` / `mcu_wrq` in 1: one-clock MCU read/write request strobes.
- `mcu_addr` in 24, `mcu_wrdata` in 8: sampled with the strobe.
- `mcu_rddata` out 8: MCU read result.
- `mcu_rq_rdy` out 1: high when no MCU request is pending or in progress.
- `mcu_done` out 1: one-clock pulse at MCU access completion (read or write).
- `sram_addr` out 24, `sram_dout` out 8, `sram_din` in 8.
- `sram_oe_data` out 1: drive `sram_dout` onto the bus.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` out 1: active-low SRAM strobes.

## Operation
- States: IDLE, SRD (SNES read), SWR (SNES write), MRD, MWR, REC.
- Request capture:
  - SNES strobe with `snes_hit=1` latches address/data/type into a one-deep SNES slot (`spend`).
  - A write additionally needs `snes_writable=1`; otherwise the strobe is dropped silently.
  - MCU strobe latches into the MCU slot (`mpend`) and drops `mcu_rq_rdy` the next clock.
  - An MCU strobe while `mcu_rq_rdy=0` is ignored.
- IDLE arbitration:
  - `spend` is taken first.
  - Else `mpend` is taken.
  - The chosen slot's address drives `sram_addr` and the counter loads `ACC_CYCLES-1`.
- Access states:
  - CE_n=0 throughout.
  - Read: OE_n=0, WE_n=1, `sram_oe_data`=0.
  - Write: WE_n=0, OE_n=1, `sram_oe_data`=1, `sram_dout` = latched data.
  - Counter decrements each clock. At count 0:
    - Reads capture `sram_din` into `snes_rddata`/`mcu_rddata` and pulse the valid/done output.
    - The state moves to REC and the slot clears.
- REC: all strobes deasserted and `sram_oe_data`=0 for exactly one clock, then IDLE.
- No preemption: an SNES strobe arriving during an MCU access waits until that access and REC finish. Worst-case SNES wait is ACC_CYCLES+1 clocks.
- A second SNES strobe while `spend` is still set overwrites the slot; the newer SNES cycle wins and the older is discarded. No error flag.
- Simultaneous SNES and MCU strobes in one clock: both latch, SNES is served first.
- Reset:
  - State IDLE, slots cleared.
  - `sram_ce_n`/`oe_n`/`we_n`=1, `sram_oe_data`=0, `sram_addr`=0, `sram_dout`=0.
  - `snes_rddata`/`mcu_rddata`=0, pulses 0, `mcu_rq_rdy`=1.
  - Reset mid-access aborts immediately; strobes are high the clock after reset is sampled.

## Timing
- All outputs are registered; strobes change only on CLK rising edge.
- SNES read latency, strobe (clock 0) to `snes_rd_valid`, idle bus: clock 0 latch, clock 1 IDLE→SRD with strobes asserted, then ACC_CYCLES clocks of access, capture at last access clock. Pulse is at clock 1+ACC_CYCLES (5 for default).
- MCU latency from an idle bus is the same (5 clocks). `mcu_rq_rdy` rises the clock after `mcu_done`.
- Bus occupancy per access: ACC_CYCLES+1 clocks (access plus REC). Back-to-back accesses never overlap, and WE_n/OE_n are never both low.
- `sram_addr` and `sram_dout` are stable for the whole access, set on the same edge CE_n falls.

## Test plan
- Reset: hold RST_N=0 mid-MWR for 1 clock -> next clock CE_n=WE_n=1, `sram_oe_data`=0, `mcu_rq_rdy`=1.
- SNES read, addr 0x123456, sram_din=0xA5 -> `sram_addr`=0x123456 for 4 clocks with OE_n=0, `snes_rd_valid` 5 clocks after strobe, `snes_rddata`=0xA5.
- SNES write with `snes_writable`=0 -> no SRAM activity. Same with =1, data 0x3C -> WE_n low 4 clocks, `sram_dout`=0x3C, `sram_oe_data`=1.
- Simultaneous MCU read (0x000010) and SNES read (0x400000) -> SNES access first, REC clock, then MCU access. `mcu_done` at clock 10, `mcu_rq_rdy`=1 at clock 11.
- SNES strobe 1 clock into an MCU write -> MCU write completes unaltered. SNES access starts at most 5 clocks later.
- MCU strobe while `mcu_rq_rdy`=0 -> ignored; exactly one `mcu_done` for the original request, with its original data.
